agu_req_queue: RTL and testbench
================================

# agu_req_queue

Address-request queue between the AGU and the data-cache port. Captures each valid AGU address result with its memory-operation attributes in a small FIFO. Rejects word-misaligned addresses with a one-cycle exception pulse. Presents queued requests to the D-cache side through a valid/ready handshake. Fully discards its contents on a pipeline flush.

## Interface
- `DEPTH`, default 4: number of FIFO entries; a power of two, at least 2.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): address and store-data width.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `flush` in 1: discards all queued entries and any pending exception.
- `in_valid` in 1: AGU result valid.
- `in_addr` in DATA_WIDTH: AGU result (effective address).
- `in_is_store` in 1: 1 means store, 0 means load.
- `in_data` in DATA_WIDTH: store data; ignored for loads but still captured.
- `in_ready` out 1: queue can accept, equal to (count != DEPTH).
- `req_valid` out 1: head entry present, equal to (count != 0).
- `req_addr` out DATA_WIDTH: head entry address.
- `req_is_store` out 1: head entry operation type.
- `req_data` out DATA_WIDTH: head entry store data.
- `req_ready` in 1: D-cache accepts the head entry.
- `misalign_valid` out 1: one-cycle pulse flagging a rejected misaligned request.
- `misalign_addr` out DATA_WIDTH: the offending address, held until the next misalign event or reset.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is DEPTH entries of {addr, is_store, data}, with write pointer `wr_ptr`, read pointer `rd_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy `count`.
- Accept condition: `in_valid && in_ready`.
- Aligned accept (`in_addr[1:0] == 2'b00`): write the entry at `wr_ptr`, increment `wr_ptr` with wrap.
- Misaligned accept: nothing enqueued, pointers unchanged. Next cycle `misalign_valid`=1 and `misalign_addr`=`in_addr`. Otherwise `misalign_valid`=0.
- `in_valid` while full: ignored entirely, including the misalign check. The producer must hold the request.
- Dequeue condition: `req_valid && req_ready`. Increment `rd_ptr` with wrap.
- Count update: +1 on aligned enqueue only, -1 on dequeue only, unchanged when both or neither occur.
- Enqueue and dequeue in the same cycle are legal at any occupancy below DEPTH.
- Head outputs read combinationally from entry `rd_ptr`. While `req_valid`=1 and `req_ready`=0, `req_addr`, `req_is_store` and `req_data` remain stable.
- Flush has highest priority:
  - `wr_ptr`, `rd_ptr` and `count` return to 0 next cycle.
  - A same-cycle enqueue is dropped and any same-cycle misalign is not reported.
  - A same-cycle dequeue handshake still counts as accepted by the D-cache. The queue simply ends empty.
- Reset (`rst_n`=0 at a clock edge):
  - pointers, `count`, `misalign_valid` and `misalign_addr` go to 0;
  - all storage entries clear to 0, so `req_addr`, `req_data` and `req_is_store` read 0;
  - `in_ready`=1 and `req_valid`=0.
- Reset overrides flush and all traffic.

## Timing
- Enqueue-to-`req_valid` latency is 1 cycle. There is no input-to-output bypass when empty.
- `in_ready` and `req_valid` are derived only from registered `count`. There is no combinational path from `req_ready` or `in_valid` to `in_ready`.
- Full throughput: one enqueue and one dequeue per cycle in steady state.
- `misalign_valid` is asserted exactly 1 cycle after the offending accept and lasts 1 cycle. Back-to-back misaligned inputs produce back-to-back pulses.
- After a flush at edge N, `req_valid`=0 and `in_ready`=1 from edge N onward. A new request offered in cycle N+1 appears at `req_valid` in cycle N+2.

## Test plan
- Reset then idle: all outputs 0 except `in_ready`=1; `count`=0.
- Enqueue 0x1000 (load), then 0x2004 (store, data 0xDEADBEEF) with `req_ready`=0:
  - `req_valid` rises 1 cycle after the first accept;
  - the head holds 0x1000 stable;
  - `count`=2.
  - Then with `req_ready`=1, 0x1000 and then 0x2004/0xDEADBEEF dequeue in order.
- Fill to DEPTH=4 with `req_ready`=0: `in_ready`=0, and a 5th `in_valid` is not stored. Raise `req_ready` for 1 cycle: `count`=3, `in_ready`=1, and the head is the 2nd entry. Then stream 8 entries with `in_valid`=`req_ready`=1 to prove pointer wrap and order.
- Misaligned address 0x1002 offered when not full: no enqueue; next cycle `misalign_valid`=1 with `misalign_addr`=0x1002, then 0. Send 0x1001 and 0x1003 back-to-back: two consecutive pulses.
- Queue holding 3 entries, assert `flush` together with `in_valid` (0x3000) and a dequeue: next cycle `count`=0, `req_valid`=0, and 0x3000 never appears.
- Assert `rst_n`=0 with 2 entries queued and a misalign pulse pending: next cycle everything is cleared to reset values.

Source files
------------

// File: rtl/agu_req_queue.sv
// Address-request queue between the AGU and the D-cache port: aligned requests
// are buffered in a small FIFO, word-misaligned ones are rejected with a pulse.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module agu_req_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_addr,
  input  logic                       in_is_store,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       req_valid,
  output logic [DATA_WIDTH-1:0]      req_addr,
  output logic                       req_is_store,
  output logic [DATA_WIDTH-1:0]      req_data,
  input  logic                       req_ready,
  output logic                       misalign_valid,
  output logic [DATA_WIDTH-1:0]      misalign_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic                  mem_st_q   [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  mis_valid_q, mis_valid_d;
  logic [DATA_WIDTH-1:0] mis_addr_q, mis_addr_d;

  logic accept, aligned, enq, mis, deq;

  // Both flow-control outputs depend only on registered occupancy.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign req_valid = (count_q != '0);

  assign accept  = in_valid && in_ready;
  assign aligned = (in_addr[1:0] == 2'b00);
  assign enq     = accept && aligned && !flush;
  assign mis     = accept && !aligned && !flush;
  assign deq     = req_valid && req_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mis_valid_d = mis;
    mis_addr_d  = mis ? in_addr : mis_addr_q;
    if (flush) begin
      // A same-cycle dequeue still completes; the queue simply ends empty.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mis_valid_q <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mis_valid_q <= mis_valid_d;
      mis_addr_q  <= mis_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
        mem_st_q[i]   <= 1'b0;
      end
    end else if (enq) begin
      mem_addr_q[wr_ptr_q] <= in_addr;
      mem_data_q[wr_ptr_q] <= in_data;
      mem_st_q[wr_ptr_q]   <= in_is_store;
    end
  end

  assign req_addr       = mem_addr_q[rd_ptr_q];
  assign req_data       = mem_data_q[rd_ptr_q];
  assign req_is_store   = mem_st_q[rd_ptr_q];
  assign misalign_valid = mis_valid_q;
  assign misalign_addr  = mis_addr_q;
  assign count          = count_q;

endmodule

// File: tb/tb_agu_req_queue.sv
// Scoreboard bench for agu_req_queue: directed traffic pushes expected head
// entries and misalign addresses; a negedge monitor pops and compares them.
module tb_agu_req_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_is_store, req_ready;
  logic [DW-1:0] in_addr, in_data;
  logic          in_ready, req_valid, req_is_store, misalign_valid;
  logic [DW-1:0] req_addr, req_data, misalign_addr;
  logic [2:0]    count;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic          st;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          sb[$];
  logic [DW-1:0] mq[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            exp_cnt = 0;
  bit            mon_en = 1'b0;

  agu_req_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_addr(in_addr), .in_is_store(in_is_store), .in_data(in_data),
    .in_ready(in_ready), .req_valid(req_valid), .req_addr(req_addr),
    .req_is_store(req_is_store), .req_data(req_data), .req_ready(req_ready),
    .misalign_valid(misalign_valid), .misalign_addr(misalign_addr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares the presented head / misalign pulse against expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_valid === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_req", req_addr, '1);
        else begin
          chk("req_addr", req_addr, sb[0].addr);
          chk("req_is_store", {31'd0, req_is_store}, {31'd0, sb[0].st});
          chk("req_data", req_data, sb[0].data);
          if (req_ready) void'(sb.pop_front());
        end
      end
      if (misalign_valid === 1'b1) begin
        if (mq.size() == 0) chk("unexpected_misalign", misalign_addr, '1);
        else chk("misalign_addr", misalign_addr, mq.pop_front());
      end
    end
  end

  // Advance one clock, recording what the model expects the DUT to do.
  task automatic step();
    bit acc, dq;
    acc = rst_n && !flush && in_valid && (exp_cnt != DEPTH);
    dq  = rst_n && req_ready && (exp_cnt != 0);
    if (acc && in_addr[1:0] == 2'b00) sb.push_back('{in_addr, in_is_store, in_data});
    else if (acc) mq.push_back(in_addr);
    if (!rst_n || flush) exp_cnt = 0;
    else exp_cnt = exp_cnt + ((acc && in_addr[1:0] == 2'b00) ? 1 : 0) - (dq ? 1 : 0);
    @(posedge clk);
    #1;
    if (!rst_n) begin sb.delete(); mq.delete(); end
    else if (flush) sb.delete();
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, {29'd0, count}, exp_cnt);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_cnt != DEPTH});
    chk({nm, "_req_valid"}, {31'd0, req_valid}, {31'd0, exp_cnt != 0});
  endtask

  task automatic offer(input logic [DW-1:0] a, input logic st, input logic [DW-1:0] d);
    in_valid = 1'b1; in_addr = a; in_is_store = st; in_data = d;
    step();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk_state(nm);
    chk({nm, "_req_addr"}, req_addr, '0);
    chk({nm, "_req_data"}, req_data, '0);
    chk({nm, "_req_is_store"}, {31'd0, req_is_store}, '0);
    chk({nm, "_mis_valid"}, {31'd0, misalign_valid}, '0);
    chk({nm, "_mis_addr"}, misalign_addr, '0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_is_store = 1'b0;
    in_addr = '0; in_data = '0; req_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk_reset_vals("reset");

    // Two requests held at the head, then drained in order.
    offer(32'h1000, 1'b0, 32'h1111_1111);
    chk("latency_req_valid", {31'd0, req_valid}, 32'd1);
    offer(32'h2004, 1'b1, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    step();
    chk_state("two_held");
    req_ready = 1'b1;
    step(); step();
    req_ready = 1'b0;
    chk_state("drained");

    // Fill, blocked 5th request, single dequeue, then streaming wrap.
    for (int i = 0; i < 4; i++) offer(32'h4000 + 32'(i * 4), 1'(i), 32'hA000 + 32'(i));
    chk_state("full");
    offer(32'h5000, 1'b0, 32'h5555);
    chk_state("full_blocked");
    in_valid = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk_state("one_deq");
    chk("head_second", req_addr, 32'h4004);
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++) offer(32'h6000 + 32'(i * 4), 1'(i + 1), 32'hB000 + 32'(i));
    chk_state("stream");
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    req_ready = 1'b0;
    chk_state("stream_drained");

    // Misaligned requests.
    offer(32'h1002, 1'b0, 32'h0);
    in_valid = 1'b0;
    chk_state("mis_no_enq");
    step();
    chk("mis_pulse_end", {31'd0, misalign_valid}, 32'd0);
    chk("mis_addr_held", misalign_addr, 32'h1002);
    offer(32'h1001, 1'b1, 32'h0);
    offer(32'h1003, 1'b0, 32'h0);
    in_valid = 1'b0;
    step();
    chk("mis_b2b_end", {31'd0, misalign_valid}, 32'd0);

    // Flush with concurrent enqueue and dequeue.
    for (int i = 0; i < 3; i++) offer(32'h7000 + 32'(i * 4), 1'b0, 32'hC000 + 32'(i));
    flush = 1'b1; req_ready = 1'b1;
    offer(32'h3000, 1'b1, 32'h3333);
    flush = 1'b0; in_valid = 1'b0; req_ready = 1'b0;
    chk_state("flushed");
    offer(32'h8000, 1'b1, 32'h8888);
    in_valid = 1'b0;
    chk_state("post_flush_enq");
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;

    // Reset with queued entries and a misalign pulse visible.
    offer(32'h9000, 1'b0, 32'h9990);
    offer(32'h9004, 1'b1, 32'h9994);
    offer(32'h9002, 1'b0, 32'h0);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_vals("mid_reset");

    step();
    chk("sb_leftover", 32'(sb.size()), 32'd0);
    chk("mq_leftover", 32'(mq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
